// File: rtl/seq_lock_p.sv
// Serial code lock: framed CODE_LEN-bit attempts, timed unlock window, lockout after repeated failures.
// Define SEQ_LOCK_PROG_EN to allow reprogramming the code while unlocked.
module seq_lock_p #(
  parameter int                  CODE_LEN       = 4,
  parameter logic [CODE_LEN-1:0] CODE           = 4'b0100,
  parameter int                  MAX_FAILS      = 3,
  parameter int                  UNLOCK_CYCLES  = 8,
  parameter int                  LOCKOUT_CYCLES = 16,
  localparam int                 FW = $clog2(MAX_FAILS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                data_valid,
  input  logic                data,
  input  logic                attempt_clr,
  input  logic                prog_en,
  input  logic [CODE_LEN-1:0] prog_code,
  output logic                unlock,
  output logic                locked_out,
  output logic [FW-1:0]       fail_cnt
);

  localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ?
                        UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam int CW = $clog2(CODE_LEN + 1);

  typedef enum logic [1:0] {
    S_COLLECT  = 2'd0,
    S_UNLOCKED = 2'd1,
    S_LOCKOUT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CODE_LEN-1:0] shift_q, shift_d;
  logic [FW-1:0]       fail_q, fail_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [CODE_LEN-1:0] code_q;
  logic [CODE_LEN-1:0] attempt;
  logic                prog_hit;

  assign attempt = {shift_q[CODE_LEN-2:0], data};

`ifdef SEQ_LOCK_PROG_EN
  logic [CODE_LEN-1:0] code_d;

  assign prog_hit = prog_en;

  always_comb begin
    code_d = code_q;
    if (state_q == S_UNLOCKED && prog_en)
      code_d = prog_code;
  end

  always_ff @(posedge clk) begin
    if (reset) code_q <= CODE;
    else       code_q <= code_d;
  end
`else
  logic unused_prog;

  assign prog_hit    = 1'b0;
  assign code_q      = CODE;
  assign unused_prog = ^{prog_en, prog_code};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_COLLECT;
      cnt_q   <= '0;
      shift_q <= '0;
      fail_q  <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      fail_q  <= fail_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    fail_d  = fail_q;
    timer_d = timer_q;
    unique case (state_q)
      S_COLLECT: begin
        // a clear wins over a bit arriving in the same cycle
        if (attempt_clr) begin
          cnt_d   = '0;
          shift_d = '0;
        end else if (data_valid) begin
          shift_d = attempt;
          if (cnt_q == CW'(CODE_LEN - 1)) begin
            cnt_d = '0;
            if (attempt == code_q) begin
              state_d = S_UNLOCKED;
              fail_d  = '0;
              timer_d = TW'(UNLOCK_CYCLES);
            end else if (fail_q == FW'(MAX_FAILS - 1)) begin
              state_d = S_LOCKOUT;
              fail_d  = FW'(MAX_FAILS);
              timer_d = TW'(LOCKOUT_CYCLES);
            end else begin
              fail_d = fail_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_UNLOCKED: begin
        if (prog_hit || timer_q == TW'(1)) begin
          state_d = S_COLLECT;
          timer_d = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_LOCKOUT: begin
        if (timer_q == TW'(1)) begin
          state_d = S_COLLECT;
          timer_d = '0;
          fail_d  = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  always_comb begin
    unlock     = (state_q == S_UNLOCKED);
    locked_out = (state_q == S_LOCKOUT);
    fail_cnt   = fail_q;
  end

endmodule

// File: tb/tb_seq_lock_p.sv
// Self-checking bench for seq_lock_p: per-scenario tasks, expected
// {unlock, locked_out, fail_cnt} values queued with the stimulus.
module tb_seq_lock_p;

  logic       clk = 1'b0;
  logic       reset;
  logic       data_valid;
  logic       data;
  logic       attempt_clr;
  logic       prog_en;
  logic [3:0] prog_code;
  logic       unlock;
  logic       locked_out;
  logic [1:0] fail_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       rst;
    logic       dv;
    logic       d;
    logic       clr;
    logic       pe;
    logic [3:0] pc;
  } stim_t;

  stim_t      stim_q[$];
  logic [3:0] exp_q[$];

  localparam logic [3:0] Z  = 4'b0000;
  localparam logic [3:0] U  = 4'b1000;
  localparam logic [3:0] F1 = 4'b0001;
  localparam logic [3:0] F2 = 4'b0010;
  localparam logic [3:0] L3 = 4'b0111;

  seq_lock_p dut (
    .clk        (clk),
    .reset      (reset),
    .data_valid (data_valid),
    .data       (data),
    .attempt_clr(attempt_clr),
    .prog_en    (prog_en),
    .prog_code  (prog_code),
    .unlock     (unlock),
    .locked_out (locked_out),
    .fail_cnt   (fail_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] obs();
    return {unlock, locked_out, fail_cnt};
  endfunction

  task automatic add(input logic rst, input logic dv, input logic d,
                     input logic clr, input logic pe,
                     input logic [3:0] pc, input logic [3:0] e);
    stim_t s;
    s = '{rst: rst, dv: dv, d: d, clr: clr, pe: pe, pc: pc};
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic add_code(input logic [3:0] c, input logic [3:0] emid,
                          input logic [3:0] elast);
    for (int i = 0; i < 4; i++)
      add(1'b0, 1'b1, c[3-i], 1'b0, 1'b0, 4'h0, (i == 3) ? elast : emid);
  endtask

  task automatic add_idle(input int n, input logic dv, input logic d,
                          input logic [3:0] e);
    for (int i = 0; i < n; i++)
      add(1'b0, dv, d, 1'b0, 1'b0, 4'h0, e);
  endtask

  task automatic apply(input stim_t s);
    reset       = s.rst;
    data_valid  = s.dv;
    data        = s.d;
    attempt_clr = s.clr;
    prog_en     = s.pe;
    prog_code   = s.pc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] e;
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'hF, Z);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, Z);
    for (int i = 0; stim_q.size() > 0; i++) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL test_reset step %0d got %b want %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_unlock();
    logic [3:0] e;
    add_code(4'b0100, Z, U);
    add_idle(7, 1'b0, 1'b0, U);
    add_idle(1, 1'b0, 1'b0, Z);
    for (int i = 0; stim_q.size() > 0; i++) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL test_unlock step %0d got %b want %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_lockout();
    logic [3:0] e;
    logic [3:0] c;
    c = 4'b0100;
    add_code(4'b1111, Z, F1);
    add_code(4'b1111, F1, F2);
    add_code(4'b1111, F2, L3);
    for (int i = 0; i < 16; i++)
      add(1'b0, 1'b1, c[3-(i%4)], (i == 6), 1'b1, 4'b1111,
          (i < 15) ? L3 : Z);
    add_code(4'b0100, Z, U);
    add_idle(7, 1'b0, 1'b0, U);
    add_idle(1, 1'b0, 1'b0, Z);
    for (int i = 0; stim_q.size() > 0; i++) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL test_lockout step %0d got %b want %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_clear();
    logic [3:0] e;
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, Z);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, Z);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, Z);
    add_code(4'b0100, Z, U);
    add_idle(7, 1'b0, 1'b0, U);
    add_idle(1, 1'b0, 1'b0, Z);
    for (int i = 0; stim_q.size() > 0; i++) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL test_clear step %0d got %b want %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] e;
    add_code(4'b0100, Z, U);
    add_idle(7, 1'b1, 1'b1, U);
    add_idle(1, 1'b1, 1'b1, Z);
    add_code(4'b0100, Z, U);
    add_idle(7, 1'b0, 1'b0, U);
    add_idle(1, 1'b0, 1'b0, Z);
    for (int i = 0; stim_q.size() > 0; i++) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL test_back_to_back step %0d got %b want %b",
                 i, obs(), e);
      end
    end
  endtask

  task automatic test_prog();
    logic [3:0] e;
    add_code(4'b0100, Z, U);
    add_idle(2, 1'b0, 1'b0, U);
`ifdef SEQ_LOCK_PROG_EN
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1011, Z);
    add_code(4'b0100, Z, F1);
    add_code(4'b1011, F1, U);
    add_idle(7, 1'b0, 1'b0, U);
    add_idle(1, 1'b0, 1'b0, Z);
`else
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1011, U);
    add_idle(4, 1'b0, 1'b0, U);
    add_idle(1, 1'b0, 1'b0, Z);
    add_code(4'b0100, Z, U);
    add_idle(7, 1'b0, 1'b0, U);
    add_idle(1, 1'b0, 1'b0, Z);
`endif
    for (int i = 0; stim_q.size() > 0; i++) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL test_prog step %0d got %b want %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] e;
    add_code(4'b1111, Z, F1);
    add_code(4'b1111, F1, F2);
    add_code(4'b1111, F2, L3);
    add_idle(4, 1'b1, 1'b0, L3);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, Z);
    add_code(4'b0100, Z, U);
    add_idle(2, 1'b0, 1'b0, U);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1011, Z);
    add_code(4'b1111, Z, F1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, F1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, Z);
    add_code(4'b0100, Z, U);
    add_idle(7, 1'b0, 1'b0, U);
    add_idle(1, 1'b0, 1'b0, Z);
    for (int i = 0; stim_q.size() > 0; i++) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL test_reset_mid step %0d got %b want %b",
                 i, obs(), e);
      end
    end
  endtask

  task automatic test_fail_then_pass();
    logic [3:0] e;
    add_code(4'b1101, Z, F1);
    add_code(4'b0100, F1, U);
    add_idle(7, 1'b0, 1'b0, U);
    add_idle(1, 1'b0, 1'b0, Z);
    for (int i = 0; stim_q.size() > 0; i++) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL test_fail_then_pass step %0d got %b want %b",
                 i, obs(), e);
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    data_valid  = 1'b0;
    data        = 1'b0;
    attempt_clr = 1'b0;
    prog_en     = 1'b0;
    prog_code   = 4'h0;
    test_reset();
    test_unlock();
    test_lockout();
    test_clear();
    test_back_to_back();
    test_prog();
    test_reset_mid();
    test_fail_then_pass();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
